// File: rtl/wb_interconnect_if.sv
// wb_interconnect_if: bundles the primary-side and secondary-side Wishbone
// signals of the single-primary interconnect.
//   Primary side  : p_cyc, p_stb, p_we, p_addr, p_dat_w -> interconnect
//                   p_dat_r, p_ack, p_err               <- interconnect
//   Secondary side: s_cyc, s_stb (one-hot), s_we, s_addr, s_dat_w -> secondaries
//                   s_dat_r (NUM_SEC packed slices), s_ack (per secondary) <- secondaries
// Modports:
//   slave  - the interconnect itself (it is the slave of the primary core)
//   master - the surrounding system: the primary core plus the secondaries
interface wb_interconnect_if #(
  parameter int DATA_SIZE = 64,
  parameter int ADDR_SIZE = 32,
  parameter int NUM_SEC   = 5
);
  logic                         p_cyc;
  logic                         p_stb;
  logic                         p_we;
  logic [ADDR_SIZE-1:0]         p_addr;
  logic [DATA_SIZE-1:0]         p_dat_w;
  logic [DATA_SIZE-1:0]         p_dat_r;
  logic                         p_ack;
  logic                         p_err;
  logic [NUM_SEC-1:0]           s_cyc;
  logic [NUM_SEC-1:0]           s_stb;
  logic                         s_we;
  logic [ADDR_SIZE-1:0]         s_addr;
  logic [DATA_SIZE-1:0]         s_dat_w;
  logic [NUM_SEC*DATA_SIZE-1:0] s_dat_r;
  logic [NUM_SEC-1:0]           s_ack;

  modport slave (
    input  p_cyc, p_stb, p_we, p_addr, p_dat_w,
    output p_dat_r, p_ack, p_err,
    output s_cyc, s_stb, s_we, s_addr, s_dat_w,
    input  s_dat_r, s_ack
  );

  modport master (
    output p_cyc, p_stb, p_we, p_addr, p_dat_w,
    input  p_dat_r, p_ack, p_err,
    input  s_cyc, s_stb, s_we, s_addr, s_dat_w,
    output s_dat_r, s_ack
  );
endinterface

// File: rtl/wb_interconnect.sv
// wb_interconnect: single-primary Wishbone interconnect. Latches one primary
// request, decodes the target secondary from p_addr[SEL_LSB +: SEL_BITS],
// strobes exactly that secondary until it acks, then returns registered read
// data with a one-cycle p_ack. Unmapped indices (and, when compiled in, a bus
// timeout) return a one-cycle p_err with p_dat_r = 0.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset; drops any in-flight transaction
//   bus   - wb_interconnect_if.slave, primary and secondary buses
// Optional feature macro: WB_TIMEOUT_EN (BUSY timeout after TIMEOUT cycles).
// Without it BUSY waits for s_ack indefinitely.
module wb_interconnect #(
  parameter int DATA_SIZE = 64,
  parameter int ADDR_SIZE = 32,
  parameter int NUM_SEC   = 5,
  parameter int SEL_BITS  = 3,
  parameter int SEL_LSB   = 28,
  parameter int TIMEOUT   = 255
) (
  input logic            clk,
  input logic            rst_n,
  wb_interconnect_if.slave bus
);

  if (NUM_SEC < 1 || NUM_SEC > (2 ** SEL_BITS) || TIMEOUT < 2) begin : g_bad_cfg
    $error("wb_interconnect: illegal NUM_SEC/SEL_BITS/TIMEOUT combination");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_SIZE-1:0]  addr_reg;
  logic                  we_reg;
  logic [DATA_SIZE-1:0]  dat_w_reg;
  logic [DATA_SIZE-1:0]  dat_r_reg;
  logic [SEL_BITS-1:0]   idx_reg;

  logic                  req;
  logic [SEL_BITS-1:0]   req_idx;
  logic                  req_unmapped;
  logic [NUM_SEC-1:0]    sel_onehot;
  logic                  sel_ack;
  logic [DATA_SIZE-1:0]  sel_dat;
  logic                  timeout_hit;

  assign req          = bus.p_cyc & bus.p_stb;
  assign req_idx      = bus.p_addr[SEL_LSB +: SEL_BITS];
  assign req_unmapped = ({1'b0, req_idx} >= (SEL_BITS + 1)'(NUM_SEC));

  // One-hot decode of the latched index; acks on other lines are masked off
  // so late self-clearing acks from a previous secondary cannot complete us.
  for (genvar gi = 0; gi < NUM_SEC; gi++) begin : g_sel
    assign sel_onehot[gi] = (idx_reg == SEL_BITS'(gi));
  end

  assign sel_ack = |(bus.s_ack & sel_onehot);

  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < NUM_SEC; k++) begin
      if (sel_onehot[k]) sel_dat = bus.s_dat_r[k*DATA_SIZE +: DATA_SIZE];
    end
  end

`ifdef WB_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  logic [TIMER_W-1:0] timer_reg;

  assign timeout_hit = (timer_reg == TIMER_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reg <= '0;
    end else if (state_reg == IDLE) begin
      timer_reg <= '0;
    end else if (state_reg == BUSY && !sel_ack) begin
      timer_reg <= timer_reg + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; an ack in the timeout cycle takes priority
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req) state_next = req_unmapped ? ERR : BUSY;
      BUSY: begin
        if (sel_ack)          state_next = RESP;
        else if (timeout_hit) state_next = ERR;
      end
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latches and response data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      dat_w_reg <= '0;
      idx_reg   <= '0;
      dat_r_reg <= '0;
    end else begin
      if (state_reg == IDLE && req) begin
        addr_reg  <= bus.p_addr;
        we_reg    <= bus.p_we;
        dat_w_reg <= bus.p_dat_w;
        idx_reg   <= req_idx;
      end
      if (state_reg == BUSY && sel_ack) dat_r_reg <= sel_dat;
      else if (state_next == ERR)       dat_r_reg <= '0;
    end
  end

  // Outputs: decoded from state and registers only, so reset clears them
  // without waiting for a clock edge.
  always_comb begin
    bus.s_cyc   = (state_reg == BUSY) ? sel_onehot : '0;
    bus.s_stb   = (state_reg == BUSY) ? sel_onehot : '0;
    bus.s_we    = we_reg;
    bus.s_addr  = addr_reg;
    bus.s_dat_w = dat_w_reg;
    bus.p_dat_r = dat_r_reg;
    bus.p_ack   = (state_reg == RESP);
    bus.p_err   = (state_reg == ERR);
  end

endmodule
